retire_trace_buffer: RTL and testbench

Synthesizable retirement-trace capture block that sits beside `cpu_top` and records every retired instruction (register write, load, store, NOP/branch, halt) as a timestamped entry in an on-chip FIFO. It provides the same information the simulation trace log carries, but as hardware, so it can be used on the board.

- Parametrised in data width, FIFO depth and number of retire lanes.
- Adds a cycle watchdog, overflow accounting and a valid/ready drain port for a debug reader or DMA engine.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 39 +++
 rtl/retire_trace_buffer.sv | 112 +++++++++++
 tb/tb_retire_trace_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: entry kinds, state encoding and entry layout shared by the
// retirement trace buffer and its readers.
package trace_pkg;
  localparam int TR_XLEN = 32;
  localparam int TR_CNT_W = 32;
  typedef enum logic [2:0] {
    REG   = 3'd0,
    LOAD  = 3'd1,
    STORE = 3'd2,
    NOP   = 3'd3,
    HALT  = 3'd4
  } trace_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_TIMEOUT} trace_state_e;
  typedef struct packed {
    trace_kind_e         kind;
    logic [TR_CNT_W-1:0] inum;
    logic [TR_CNT_W-1:0] cycle;
    logic [TR_XLEN-1:0]  pc;
    logic [TR_XLEN-1:0]  data;
    logic [TR_XLEN-1:0]  addr;
    logic [4:0]          rd;
  } trace_entry_t;
  function automatic trace_kind_e classify(input logic regwr, memrd, memwr, halt);
    return regwr ? (memrd ? LOAD : REG) : halt ? HALT : memwr ? STORE : NOP;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular buffer taking up to LANES pushes and one pop per cycle.
// The head reads as zero while empty so the drain port idles at all-zero.
module trace_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int LANES = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int NW = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NW-1:0]      push_cnt,
  input  logic [LANES*W-1:0] push_data,
  input  logic               pop,
  output logic [W-1:0]       head,
  output logic [AW:0]        occ
);
  localparam int OW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] occ_q;
  logic do_pop;
  assign do_pop = pop && occ_q != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      occ_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push_cnt);
      rp_q <= rp_q + AW'(do_pop);
      occ_q <= occ_q + OW'(push_cnt) - OW'(do_pop);
    end
  always_ff @(posedge clk)
    for (int j = 0; j < LANES; j++)
      if (j < int'(push_cnt)) mem_q[wp_q + AW'(j)] <= push_data[j*W +: W];
  assign head = occ_q != '0 ? mem_q[rp_q] : '0;
  assign occ = occ_q;
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: classifies and packs retiring lanes into timestamped
// trace entries, with watchdog, overflow accounting and a valid/ready drain.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LANES = 1,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [LANES-1:0]   ret_valid,
  input  logic [LANES-1:0]   ret_regwr,
  input  logic [LANES-1:0]   ret_memrd,
  input  logic [LANES-1:0]   ret_memwr,
  input  logic [LANES-1:0]   ret_halt,
  input  logic [LANES*XLEN-1:0] ret_pc,
  input  logic [LANES*XLEN-1:0] ret_data,
  input  logic [LANES*XLEN-1:0] ret_addr,
  input  logic [LANES*5-1:0] ret_reg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_kind,
  output logic [CNT_W-1:0]   out_inum,
  output logic [CNT_W-1:0]   out_cycle,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_data,
  output logic [XLEN-1:0]    out_addr,
  output logic [4:0]         out_reg,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   inst_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               halted,
  output logic               timeout
);
  localparam int W = 3 + 2*CNT_W + 3*XLEN + 5;
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int NW = $clog2(LANES + 1);
  trace_state_e state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
  trace_kind_e kind [LANES];
  logic [LANES*W-1:0] group;
  logic [NW-1:0] n, push_cnt;
  logic has_halt, run, fits, tick_to;
  logic [AW:0] occ;
  logic [W-1:0] head;
  logic [CNT_W:0] drop_sum;
  // Valid lanes are compacted in program order; a HALT closes the group.
  always_comb begin
    n = '0;
    has_halt = 1'b0;
    group = '0;
    for (int l = 0; l < LANES; l++) begin
      kind[l] = classify(ret_regwr[l], ret_memrd[l], ret_memwr[l], ret_halt[l]);
      if (ret_valid[l] && !has_halt) begin
        group[int'(n)*W +: W] = {kind[l], inst_q + CNT_W'(n), cycle_q, ret_pc[l*XLEN +: XLEN],
                                 ret_data[l*XLEN +: XLEN], ret_addr[l*XLEN +: XLEN], ret_reg[l*5 +: 5]};
        has_halt = kind[l] == HALT;
        n = n + NW'(1);
      end
    end
  end
  assign run = state_q == S_RUN;
  assign fits = (OW'(DEPTH) - occ) >= OW'(n);
  assign push_cnt = run && fits ? n : '0;
  assign tick_to = cycle_q == CNT_W'(MAX_CYCLES - 1) && cycle_q != '1;
  assign drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(n);
  always_comb begin
    cycle_d = run && cycle_q != '1 ? cycle_q + CNT_W'(1) : cycle_q;
    inst_d = run ? inst_q + CNT_W'(n) : inst_q;
    drop_d = run && !fits ? (drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0]) : drop_q;
  end
  always_comb
    state_d = state_q == S_IDLE ? (en ? S_RUN : S_IDLE) :
              !run ? state_q :
              has_halt ? S_HALTED :
              tick_to ? S_TIMEOUT : S_RUN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cycle_q <= '0;
      inst_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      inst_q <= inst_d;
      drop_q <= drop_d;
    end
  always_comb begin
    halted = state_q == S_HALTED;
    timeout = state_q == S_TIMEOUT;
  end
  trace_fifo #(.W(W), .DEPTH(DEPTH), .LANES(LANES)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_cnt(push_cnt),
    .push_data(group),
    .pop(out_ready),
    .head(head),
    .occ(occ)
  );
  assign out_valid = occ != '0;
  assign {out_kind, out_inum, out_cycle, out_pc, out_data, out_addr, out_reg} = head;
  assign cycle_count = cycle_q;
  assign inst_count = inst_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: directed retire sequences checked every cycle against
// a queue-based reference model, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_retire_trace_buffer;
  import trace_pkg::*;
  localparam int L = 2, D = 4, MAXC = 10;
  logic clk = 0, rst_n = 0, en = 0, out_ready = 0;
  logic [L-1:0] ret_valid, ret_regwr, ret_memrd, ret_memwr, ret_halt;
  logic [L*32-1:0] ret_pc, ret_data, ret_addr;
  logic [L*5-1:0] ret_reg;
  logic out_valid, halted, timeout;
  logic [2:0] out_kind;
  logic [31:0] out_inum, out_cycle, out_pc, out_data, out_addr;
  logic [31:0] cycle_count, inst_count, drop_count;
  logic [4:0] out_reg;
  int checks = 0, failures = 0;

  retire_trace_buffer #(.XLEN(32), .LANES(L), .DEPTH(D), .CNT_W(32), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ret_valid(ret_valid), .ret_regwr(ret_regwr), .ret_memrd(ret_memrd),
    .ret_memwr(ret_memwr), .ret_halt(ret_halt),
    .ret_pc(ret_pc), .ret_data(ret_data), .ret_addr(ret_addr), .ret_reg(ret_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_inum(out_inum), .out_cycle(out_cycle), .out_pc(out_pc),
    .out_data(out_data), .out_addr(out_addr), .out_reg(out_reg),
    .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
    .halted(halted), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of entries, counters and a state number
  // (0 idle, 1 run, 2 halted, 3 timeout).
  trace_entry_t q[$], grp[$];
  trace_entry_t m_e;
  int m_state, m_occ0;
  bit m_pop;
  longint m_cyc, m_inst, m_drop;

  function automatic trace_kind_e kind_of(input int l);
    if (ret_regwr[l] && ret_memrd[l]) return LOAD;
    if (ret_regwr[l]) return REG;
    if (ret_halt[l]) return HALT;
    if (ret_memwr[l]) return STORE;
    return NOP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_state = 0;
      m_cyc = 0;
      m_inst = 0;
      m_drop = 0;
    end else begin
      m_occ0 = q.size();
      m_pop = m_occ0 > 0 && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_state == 1) begin
        grp.delete();
        for (int l = 0; l < L; l++) begin
          if (ret_valid[l]) begin
            m_e.kind = kind_of(l);
            m_e.inum = 32'(m_inst + grp.size());
            m_e.cycle = 32'(m_cyc);
            m_e.pc = ret_pc[l*32 +: 32];
            m_e.data = ret_data[l*32 +: 32];
            m_e.addr = ret_addr[l*32 +: 32];
            m_e.rd = ret_reg[l*5 +: 5];
            grp.push_back(m_e);
            if (m_e.kind == HALT) break;
          end
        end
        m_inst += grp.size();
        if (D - m_occ0 >= grp.size()) begin
          foreach (grp[i]) q.push_back(grp[i]);
        end else begin
          m_drop += grp.size();
          if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
        end
        if (grp.size() > 0 && grp[grp.size()-1].kind == HALT) m_state = 2;
        else if (m_cyc == MAXC - 1) m_state = 3;
        if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      end else if (m_state == 0 && en) m_state = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_kind", 32'(out_kind), 32'(q[0].kind));
        chk("out_inum", out_inum, q[0].inum);
        chk("out_cycle", out_cycle, q[0].cycle);
        chk("out_pc", out_pc, q[0].pc);
        chk("out_data", out_data, q[0].data);
        chk("out_addr", out_addr, q[0].addr);
        chk("out_reg", 32'(out_reg), 32'(q[0].rd));
      end
      chk("cycle_count", cycle_count, m_cyc[31:0]);
      chk("inst_count", inst_count, m_inst[31:0]);
      chk("drop_count", drop_count, m_drop[31:0]);
      chk("halted", 32'(halted), 32'(m_state == 2));
      chk("timeout", 32'(timeout), 32'(m_state == 3));
    end
  end

  task automatic clr();
    ret_valid = '0; ret_regwr = '0; ret_memrd = '0; ret_memwr = '0; ret_halt = '0;
    ret_pc = '0; ret_data = '0; ret_addr = '0; ret_reg = '0;
  endtask

  // a = {regwr, memrd, memwr, halt}
  task automatic setl(input int l, input logic [3:0] a, input logic [31:0] pc, d, ad,
                      input logic [4:0] r);
    ret_valid[l] = 1'b1;
    ret_regwr[l] = a[3]; ret_memrd[l] = a[2]; ret_memwr[l] = a[1]; ret_halt[l] = a[0];
    ret_pc[l*32 +: 32] = pc; ret_data[l*32 +: 32] = d; ret_addr[l*32 +: 32] = ad;
    ret_reg[l*5 +: 5] = r;
  endtask

  // Returns at a falling edge with the block in RUN and cycle_count 0.
  task automatic restart();
    @(negedge clk);
    en = 0; out_ready = 0; clr(); rst_n = 0;
    @(negedge clk);
    rst_n = 1; en = 1;
    @(negedge clk);
  endtask

  initial begin
    clr();
    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_inum", out_inum, 0);
    chk("rst counters", cycle_count | inst_count | drop_count, 0);
    chk("rst flags", 32'({halted, timeout}), 0);
    rst_n = 1;

    // single REG retire
    restart();
    setl(0, 4'b1000, 32'h10, 32'h1234, 32'h0, 5'd5);
    @(negedge clk); clr();
    chk("t1 valid", 32'(out_valid), 1);
    chk("t1 kind", 32'(out_kind), 0);
    chk("t1 inum", out_inum, 0);
    chk("t1 cycle", out_cycle, 0);
    chk("t1 reg", 32'(out_reg), 5);
    chk("t1 data", out_data, 32'h1234);
    chk("t1 pc", out_pc, 32'h10);
    chk("t1 cycle_count", cycle_count, 1);
    out_ready = 1;
    @(negedge clk);
    chk("t1 drained", 32'(out_valid), 0);

    // two lanes LOAD + STORE, then lane1-only NOP, then regwr+memwr
    restart();
    setl(0, 4'b1100, 32'h20, 32'hAA, 32'h80, 5'd3);
    setl(1, 4'b0010, 32'h24, 32'h55, 32'h40, 5'd0);
    @(negedge clk); clr();
    chk("t2 inst", inst_count, 2);
    chk("t2 kind0", 32'(out_kind), 1);
    chk("t2 inum0", out_inum, 0);
    chk("t2 addr0", out_addr, 32'h80);
    out_ready = 1;
    @(negedge clk);
    chk("t2 kind1", 32'(out_kind), 2);
    chk("t2 inum1", out_inum, 1);
    chk("t2 addr1", out_addr, 32'h40);
    chk("t2 data1", out_data, 32'h55);
    setl(1, 4'b0000, 32'h28, 32'h0, 32'h0, 5'd0);
    @(negedge clk); clr();
    chk("t2 nop kind", 32'(out_kind), 3);
    chk("t2 nop inum", out_inum, 2);
    chk("t2 nop cycle", out_cycle, 2);
    setl(0, 4'b1010, 32'h2C, 32'h77, 32'h90, 5'd7);
    @(negedge clk); clr();
    chk("t2 rw kind", 32'(out_kind), 0);
    chk("t2 rw inum", out_inum, 3);
    @(negedge clk);
    chk("t2 empty", 32'(out_valid), 0);

    // overflow with six single retires into four slots
    restart();
    for (int i = 0; i < 6; i++) begin
      setl(0, 4'b1000, 32'h100 + 32'(4*i), 32'(i), 32'h0, 5'd1);
      @(negedge clk);
    end
    clr();
    chk("t3 drop", drop_count, 2);
    chk("t3 inst", inst_count, 6);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t3 drain valid", 32'(out_valid), 1);
      chk("t3 drain inum", out_inum, 32'(i));
      @(negedge clk);
    end
    chk("t3 drained", 32'(out_valid), 0);

    // same-cycle pop gives no space; dropped HALT group still halts
    restart();
    setl(0, 4'b1000, 32'h200, 32'h1, 32'h0, 5'd1);
    setl(1, 4'b1000, 32'h204, 32'h2, 32'h0, 5'd2);
    repeat (2) @(negedge clk);
    clr();
    setl(0, 4'b1000, 32'h208, 32'h3, 32'h0, 5'd3);
    out_ready = 1;
    @(negedge clk); clr();
    chk("sp drop", drop_count, 1);
    chk("sp inst", inst_count, 5);
    out_ready = 0;
    setl(0, 4'b1000, 32'h20C, 32'h4, 32'h0, 5'd4);
    setl(1, 4'b0001, 32'h210, 32'h0, 32'h0, 5'd0);
    @(negedge clk); clr();
    chk("sp drop halt", drop_count, 3);
    chk("sp halted", 32'(halted), 1);
    chk("sp inst2", inst_count, 7);

    // HALT in lane 0 discards lane 1 and later retires
    restart();
    setl(0, 4'b0001, 32'h50, 32'h0, 32'h0, 5'd0);
    setl(1, 4'b1000, 32'h54, 32'h9, 32'h0, 5'd2);
    @(negedge clk); clr();
    chk("t4 halted", 32'(halted), 1);
    chk("t4 inst", inst_count, 1);
    chk("t4 kind", 32'(out_kind), 4);
    chk("t4 pc", out_pc, 32'h50);
    setl(0, 4'b1000, 32'h58, 32'h9, 32'h0, 5'd2);
    @(negedge clk); clr();
    chk("t4 ignored", inst_count, 1);
    out_ready = 1;
    @(negedge clk);
    chk("t4 one entry", 32'(out_valid), 0);

    // watchdog
    restart();
    repeat (9) @(negedge clk);
    chk("t5 cycle9", cycle_count, 9);
    chk("t5 not yet", 32'(timeout), 0);
    @(negedge clk);
    chk("t5 timeout", 32'(timeout), 1);
    chk("t5 cycle10", cycle_count, 10);
    setl(0, 4'b1000, 32'h60, 32'h1, 32'h0, 5'd1);
    @(negedge clk); clr();
    @(negedge clk);
    chk("t5 held", cycle_count, 10);
    chk("t5 no capture", inst_count, 0);
    chk("t5 empty", 32'(out_valid), 0);

    // asynchronous reset with three entries held
    restart();
    setl(0, 4'b1000, 32'h70, 32'h5, 32'h0, 5'd6);
    repeat (3) @(negedge clk);
    clr();
    chk("t6 held", 32'(out_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("t6 valid", 32'(out_valid), 0);
    chk("t6 counters", cycle_count | inst_count | drop_count, 0);
    chk("t6 inum", out_inum, 0);
    @(negedge clk);
    en = 0; rst_n = 1;
    setl(0, 4'b1000, 32'h74, 32'h6, 32'h0, 5'd6);
    repeat (2) @(negedge clk);
    clr();
    chk("t6 idle cycle", cycle_count, 0);
    chk("t6 idle inst", inst_count, 0);
    chk("t6 idle valid", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
